mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle integer multiply/divide unit with MIPS HI/LO result registers.
//   Sits beside the single-cycle ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   Width is parametrised. Uses a shift-add multiplier and a restoring divider, one bit per cycle.
//   A start/busy/done handshake lets the controller stall while an operation is in flight.
// PARAMETERS
//   N       32   operand and HI/LO width (>=4)
//   CNT_W   $clog2(N)+1   iteration counter width (localparam, derived from N)
// PORTS
//   clock        in   1  rising-edge clock
//   reset        in   1  asynchronous, active-low reset
//   start        in   1  request an operation; sampled only in IDLE
//   op           in   2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   inA          in   N  multiplicand / dividend
//   inB          in   N  multiplier / divisor
//   hi_wen       in   1  MTHI: HI <= wd (IDLE only)
//   lo_wen       in   1  MTLO: LO <= wd (IDLE only)
//   wd           in   N  MTHI/MTLO write data
//   busy         out  1  operation in flight; start/hi_wen/lo_wen ignored while 1
//   done         out  1  one-cycle pulse when HI/LO hold the new result
//   div_by_zero  out  1  last completed op was a divide with inB==0
//   hi           out  N  HI register (mult: upper half; div: remainder)
//   lo           out  N  LO register (mult: lower half; div: quotient)
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, counter=0.
//     Reset mid-operation aborts it; no partial result is written.
//   FSM states: IDLE, MUL, DIV, FIX, DONE.
//   IDLE: at a posedge with start=1, latch |inA|, |inB| (abs only for signed ops), the result signs, and op;
//     clear div_by_zero; busy=1 from this edge.
//     Go to MUL for op[1]==0. Go to DIV for op[1]==1 && inB!=0.
//     Go to DONE for divide with inB==0 (divide-by-zero path).
//   MUL: N cycles of shift-add on a 2N-bit accumulator; counter N-1..0; then FIX.
//   DIV: N cycles of restoring shift-subtract on a (N+1)-bit partial remainder; then FIX.
//   FIX: apply sign correction in 2's complement.
//     mult: negate 2N-bit product if signA^signB.
//     div: negate quotient if signA^signB; negate remainder if signA.
//     Then write HI/LO and go to DONE.
//   DONE: done=1, busy=0 for exactly one cycle; next state IDLE.
//     A start in DONE is ignored; start is accepted only in IDLE.
//   Latency: start accepted at edge k.
//     Normal path: HI/LO written at edge k+N+1; done high in cycle after edge k+N+1.
//     Divide-by-zero path: HI/LO unchanged; done and div_by_zero high in cycle after edge k+1.
//   div_by_zero holds its value until the next accepted start.
//   Overflow: DIV of -2^(N-1) by -1 yields LO=-2^(N-1), HI=0 (wrap, no flag).
//   Unsigned ops treat operands as N-bit unsigned; no abs/negate applied.
//   MTHI/MTLO: in IDLE, hi_wen/lo_wen write at posedge.
//     If start occurs at the same edge, the write happens and the later result overwrites it.
//     While busy, writes are dropped.
//   hi/lo are registers; stable outside the FIX->DONE write edge.
// TESTING (N=32)
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001; done exactly 33 cycles after start edge, 1 cycle wide.
//   MULT -3*7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> HI=0x40000000 LO=0.
//   DIVU 100/7 -> LO=14 HI=2; DIV -7/2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
//   MTHI 5, MTLO 9, then DIVU 10/0 -> done after 2 cycles, div_by_zero=1, HI=5 LO=9; next start clears flag.
//   start and hi_wen pulsed while busy -> ignored, result unchanged; MTLO and start at same IDLE edge -> final LO = op result.
//   Assert reset mid-MULT (cycle 10) -> hi=lo=0, busy=done=0 immediately; a new op afterwards completes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle integer multiply/divide unit with MIPS-style HI/LO registers.
//   Serves MULT/MULTU/DIV/DIVU (shift-add multiplier and restoring divider,
//   one bit per cycle) and MTHI/MTLO writes.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only in IDLE
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   inA / inB    multiplicand/dividend, multiplier/divisor
//   hi_wen       MTHI write enable (IDLE only)
//   lo_wen       MTLO write enable (IDLE only)
//   wd           MTHI/MTLO write data
//   busy         operation in flight
//   done         one-cycle pulse once HI/LO hold the new result
//   div_by_zero  last completed op was a divide by zero
//   hi / lo      HI/LO registers
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Two's complement negate when en is set (N bits).
  function automatic logic [N-1:0] f_neg(input logic [N-1:0] x, input logic en);
    return en ? ({N{1'b0}} - x) : x;
  endfunction

  // Two's complement negate when en is set (2N bits).
  function automatic logic [2*N-1:0] f_neg2(input logic [2*N-1:0] x, input logic en);
    return en ? ({(2*N){1'b0}} - x) : x;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0]   r_acc;     // mult: {partial product, multiplier}; div: low half = dividend/quotient
  logic [N:0]       r_rem;     // div partial remainder
  logic [N-1:0]     r_b;       // mult: |multiplicand|; div: |divisor|
  logic             r_op_div;
  logic             r_neg_q;   // negate product / quotient
  logic             r_neg_r;   // negate remainder
  logic             r_zero;    // divide-by-zero operation in flight
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;

  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_sign_a;
  logic             w_sign_b;
  logic             w_b_zero;
  logic             w_cnt_zero;
  logic [N:0]       w_mul_sum;
  logic [2*N-1:0]   w_mul_acc;
  logic [N:0]       w_div_shift;
  logic [N+1:0]     w_div_diff;
  logic             w_div_ok;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_quo;
  logic [N-1:0]     w_rem;
  logic             w_unused_bits;

  assign w_sign_a   = op[0] & inA[N-1];
  assign w_sign_b   = op[0] & inB[N-1];
  assign w_b_zero   = (inB == {N{1'b0}});
  assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});

  // Shift-add step: conditionally add multiplicand to the upper half, shift right.
  assign w_mul_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_b} : {(N+1){1'b0}});
  assign w_mul_acc = {w_mul_sum, r_acc[N-1:1]};

  // Restoring step: shift next dividend bit in, keep the difference if non-negative.
  assign w_div_shift = {r_rem[N-1:0], r_acc[N-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_diff[N+1];

  assign w_prod = f_neg2(r_acc, r_neg_q);
  assign w_quo  = f_neg(r_acc[N-1:0], r_neg_q);
  assign w_rem  = f_neg(r_rem[N-1:0], r_neg_r);

  // The remainder is always below the divisor, so its top bit never reaches the result.
  assign w_unused_bits = r_rem[N];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A divide by zero still passes through FIX (without
  // writing HI/LO) so its done pulse lands one edge after the start edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!op[1]) begin
            w_state_nxt = S_MUL;
          end else if (w_b_zero) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_DIV;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_DIV: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FIX;
        end else begin
          w_state_nxt = S_DIV;
        end
      end
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_MUL, S_DIV, S_FIX: w_busy_nxt = 1'b1;
      S_DONE:              w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Operand latch and iterative datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {(2*N){1'b0}};
      r_rem    <= {(N+1){1'b0}};
      r_b      <= {N{1'b0}};
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_cnt    <= CNT_W'(N - 1);
      r_b      <= op[1] ? f_neg(inB, w_sign_b) : f_neg(inA, w_sign_a);
      r_acc    <= {{N{1'b0}}, (op[1] ? f_neg(inA, w_sign_a) : f_neg(inB, w_sign_b))};
      r_rem    <= {(N+1){1'b0}};
      r_op_div <= op[1];
      r_neg_q  <= w_sign_a ^ w_sign_b;
      r_neg_r  <= w_sign_a;
      r_zero   <= op[1] & w_b_zero;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_cnt <= w_cnt_zero ? r_cnt : (r_cnt - {{(CNT_W-1){1'b0}}, 1'b1});
        end
        S_DIV: begin
          r_acc[N-1:0] <= {r_acc[N-2:0], w_div_ok};
          r_rem        <= w_div_ok ? w_div_diff[N:0] : w_div_shift;
          r_cnt        <= w_cnt_zero ? r_cnt : (r_cnt - {{(CNT_W-1){1'b0}}, 1'b1});
        end
        S_FIX: begin
          r_dbz <= r_zero;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // HI/LO registers: result write at FIX has priority over MTHI/MTLO in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi <= {N{1'b0}};
      r_lo <= {N{1'b0}};
    end else if ((r_state == S_FIX) && !r_zero) begin
      if (r_op_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*N-1:N];
        r_lo <= w_prod[N-1:0];
      end
    end else if (r_state == S_IDLE) begin
      if (hi_wen) begin
        r_hi <= wd;
      end
      if (lo_wen) begin
        r_lo <= wd;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
